// File: rtl/softmax_pkg.sv
// Shared definitions for the Q8.8 softmax datapath: element format, reduction
// mode encoding and the saturation helper used at the end of wide arithmetic.
package softmax_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_LO = -SAT_HI - 64'sd1;

    // value holds a wide_w-bit signed quantity sign-extended to 64 bits;
    // clamp it into the DATA_W-bit signed range.
    function automatic logic [DATA_W-1:0] sat_to_w(input logic signed [63:0] value,
                                                   input int wide_w);
        logic [DATA_W-1:0] res;
        if (wide_w <= DATA_W) begin
            res = value[DATA_W-1:0];
        end else if (value > SAT_HI) begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (value < SAT_LO) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = value[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/reduce_node.sv
// One registered 2:1 reduction node: sign-extended sum (one bit of growth) or
// signed maximum, advancing only when the pipeline is enabled.
module reduce_node
    import softmax_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            mode_i,
    input  logic [IN_W-1:0] a_i,
    input  logic [IN_W-1:0] b_i,
    output logic [IN_W:0]   y_o
);

    logic [IN_W:0] a_ext_s;
    logic [IN_W:0] b_ext_s;
    logic [IN_W:0] y_d;
    logic [IN_W:0] y_q;

    // Combine the two operands according to the vector's own mode.
    always_comb begin
        a_ext_s = {a_i[IN_W-1], a_i};
        b_ext_s = {b_i[IN_W-1], b_i};
        y_d     = '0;
        if (mode_i == MODE_MAX) begin
            y_d = ($signed(a_i) > $signed(b_i)) ? a_ext_s : b_ext_s;
        end else begin
            y_d = a_ext_s + b_ext_s;
        end
    end

    // Node result register, frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else if (en_i) begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N-input SUM/MAX reduction tree with a global valid/ready stall.
// S0 registers the input vector; each following stage is one tree level.
module reduce_tree_pipe
    import softmax_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = DATA_W,
    parameter int FRAC = FRAC_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    output logic           ready_in,
    input  logic           mode_in,
    input  logic [N*W-1:0] in_flat,
    output logic           valid_out,
    input  logic           ready_out,
    output logic [W-1:0]   out,
    output logic           mode_out,
    output logic [N*W-1:0] out_prop
);

    localparam int L  = $clog2(N);
    localparam int NP = 1 << L;
    localparam int WF = W + L;

    if (N < 2 || W != DATA_W || FRAC >= W) begin : g_param_check
        $error("reduce_tree_pipe: need N >= 2, W == DATA_W and FRAC < W");
    end

    logic           adv_s;
    logic [L:0]     vld_q;
    logic [L:0]     mode_q;
    logic [N*W-1:0] prop_q [L+1];

    // Every level's operands, sign-extended to the widest tree width.
    logic [WF-1:0]  lvl_s [L+1][NP];

    logic signed [63:0] fin_ext_s;

    assign adv_s    = ~vld_q[L] | ready_out;
    assign ready_in = adv_s;

    // Sideband pipeline: valid, mode and the untouched input copy per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int i = 0; i <= L; i++) begin
                prop_q[i] <= '0;
            end
        end else if (adv_s) begin
            vld_q     <= {vld_q[L-1:0], valid_in};
            mode_q    <= {mode_q[L-1:0], mode_in};
            prop_q[0] <= in_flat;
            for (int i = 1; i <= L; i++) begin
                prop_q[i] <= prop_q[i-1];
            end
        end
    end

    // Leaves come straight from the S0 copy; padding is the identity of the mode.
    for (genvar i = 0; i < NP; i++) begin : g_leaf
        if (i < N) begin : g_real
            assign lvl_s[0][i] = WF'($signed(prop_q[0][i*W +: W]));
        end else begin : g_pad
            assign lvl_s[0][i] = (mode_q[0] == MODE_MAX) ? {{(L+1){1'b1}}, {(W-1){1'b0}}}
                                                         : {WF{1'b0}};
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        for (genvar j = 0; j < NP; j++) begin : g_node
            if (j < (NP >> k)) begin : g_real
                logic [W+k-1:0] y_s;

                reduce_node #(
                    .IN_W (W + k - 1)
                ) u_node (
                    .clk    (clk),
                    .rst    (rst),
                    .en_i   (adv_s),
                    .mode_i (mode_q[k-1]),
                    .a_i    (lvl_s[k-1][2*j][W+k-2:0]),
                    .b_i    (lvl_s[k-1][2*j+1][W+k-2:0]),
                    .y_o    (y_s)
                );

                assign lvl_s[k][j] = WF'($signed(y_s));
            end else begin : g_idle
                assign lvl_s[k][j] = '0;
            end
        end
    end

    assign fin_ext_s = 64'($signed(lvl_s[L][0]));

    assign out       = sat_to_w(fin_ext_s, WF);
    assign valid_out = vld_q[L];
    assign mode_out  = mode_q[L];
    assign out_prop  = prop_q[L];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Randomised and directed bench for reduce_tree_pipe (N=8 and N=5 instances)
// against an arithmetic reference model and per-DUT result scoreboards.
module tb_reduce_tree_pipe;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0]   res;
        logic           mode;
        logic [8*W-1:0] prop;
        int             cyc;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           v8_in, r8_in, m8_in, v8_out, r8_out, m8_out;
    logic [8*W-1:0] in8, prop8;
    logic [W-1:0]   out8;
    logic           v5_in, r5_in, m5_in, v5_out, r5_out, m5_out;
    logic [5*W-1:0] in5, prop5;
    logic [W-1:0]   out5;

    xfer_t exp8[$], got8[$], exp5[$], got5[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    reduce_tree_pipe #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .valid_in(v8_in), .ready_in(r8_in), .mode_in(m8_in),
        .in_flat(in8), .valid_out(v8_out), .ready_out(r8_out), .out(out8),
        .mode_out(m8_out), .out_prop(prop8)
    );

    reduce_tree_pipe #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .valid_in(v5_in), .ready_in(r5_in), .mode_in(m5_in),
        .in_flat(in5), .valid_out(v5_out), .ready_out(r5_out), .out(out5),
        .mode_out(m5_out), .out_prop(prop5)
    );

    // Reference: exact integer sum or max of the first n elements, then clamp.
    function automatic logic [W-1:0] ref_reduce(input logic [8*W-1:0] v, input logic mode,
                                                input int n);
        longint acc, e;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            e = longint'($signed(v[i*W +: W]));
            if (mode) acc = (i == 0 || e > acc) ? e : acc;
            else      acc = acc + e;
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_elem();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h7000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: record accepted inputs and delivered outputs, then advance.
    task automatic tick();
        logic [8*W-1:0] p5;
        #1;
        p5 = '0;
        p5[5*W-1:0] = in5;
        if (!rst && v8_in && r8_in)
            exp8.push_back(xfer_t'{ref_reduce(in8, m8_in, 8), m8_in, in8, cyc});
        if (!rst && v8_out && r8_out) got8.push_back(xfer_t'{out8, m8_out, prop8, cyc});
        if (!rst && v5_in && r5_in)
            exp5.push_back(xfer_t'{ref_reduce(p5, m5_in, 5), m5_in, p5, cyc});
        if (!rst && v5_out && r5_out) begin
            p5 = '0;
            p5[5*W-1:0] = prop5;
            got5.push_back(xfer_t'{out5, m5_out, p5, cyc});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_q();
        exp8.delete(); got8.delete(); exp5.delete(); got5.delete();
    endtask

    task automatic send8(input logic [8*W-1:0] v, input logic mode);
        logic acc;
        v8_in = 1'b1; in8 = v; m8_in = mode;
        for (int k = 0; k < 50; k++) begin
            #1;
            acc = r8_in;
            tick();
            if (acc) break;
        end
        v8_in = 1'b0;
    endtask

    task automatic send5(input logic [5*W-1:0] v, input logic mode);
        logic acc;
        v5_in = 1'b1; in5 = v; m5_in = mode;
        for (int k = 0; k < 50; k++) begin
            #1;
            acc = r5_in;
            tick();
            if (acc) break;
        end
        v5_in = 1'b0;
    endtask

    task automatic drain();
        r8_out = 1'b1; r5_out = 1'b1; v8_in = 1'b0; v5_in = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (got8.size() >= exp8.size() && got5.size() >= exp5.size() && !v8_out && !v5_out)
                break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v8_in = 1'b1; v5_in = 1'b1; r8_out = 1'b0; r5_out = 1'b0;
        in8 = {4{32'($urandom)}}; in5 = {16'h1234, 64'hFEDC_BA98_7654_3210};
        tick(); tick();
        rst = 1'b0; v8_in = 1'b0; v5_in = 1'b0;
        #1;
        checks++; if (v8_out !== 1'b0) begin failures++; $display("FAIL reset_valid8 got=%b exp=0", v8_out); end
        checks++; if (out8 !== 16'h0000) begin failures++; $display("FAIL reset_out8 got=%h exp=0000", out8); end
        checks++; if (m8_out !== 1'b0) begin failures++; $display("FAIL reset_mode8 got=%b exp=0", m8_out); end
        checks++; if (prop8 !== '0) begin failures++; $display("FAIL reset_prop8 got=%h exp=0", prop8); end
        checks++; if (r8_in !== 1'b1) begin failures++; $display("FAIL reset_ready8 got=%b exp=1", r8_in); end
        checks++; if (v5_out !== 1'b0 || out5 !== 16'h0000 || r5_in !== 1'b1) begin
            failures++; $display("FAIL reset_dut5 valid=%b out=%h ready=%b exp 0/0000/1", v5_out, out5, r5_in);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (v8_out !== 1'b0 || v5_out !== 1'b0) begin
                failures++; $display("FAIL reset_ignored_in got valid8=%b valid5=%b exp 0", v8_out, v5_out);
            end
        end
        clear_q();
    endtask

    task automatic test_sum_basic();
        logic [8*W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*W +: W] = 16'((i + 1) << 8);
        clear_q();
        r8_out = 1'b1;
        send8(v, 1'b0);
        drain();
        checks++;
        if (got8.size() != 1) begin
            failures++; $display("FAIL sum_count got=%0d exp=1", got8.size());
        end else begin
            checks++; if (got8[0].res !== 16'h2400) begin failures++; $display("FAIL sum_value got=%h exp=2400", got8[0].res); end
            checks++; if (got8[0].prop !== v) begin failures++; $display("FAIL sum_prop got=%h exp=%h", got8[0].prop, v); end
            checks++; if (got8[0].mode !== 1'b0) begin failures++; $display("FAIL sum_mode got=%b exp=0", got8[0].mode); end
            checks++; if (got8[0].cyc - exp8[0].cyc != 4) begin
                failures++; $display("FAIL sum_latency got=%0d exp=4", got8[0].cyc - exp8[0].cyc);
            end
        end
    endtask

    task automatic test_max_and_sat();
        logic [8*W-1:0] v [5];
        logic [W-1:0]   want [5];
        logic           md [5];
        for (int i = 0; i < 8; i++) begin
            v[0][i*W +: W] = (i == 5) ? 16'hF000 : 16'((i + 1) << 8);
            v[1][i*W +: W] = 16'hFF00;
            v[2][i*W +: W] = 16'h7000;
            v[3][i*W +: W] = 16'h8000;
            v[4][i*W +: W] = (i < 4) ? 16'h7000 : 16'h9000;
        end
        want = '{16'h0800, 16'hFF00, 16'h7FFF, 16'h8000, 16'h0000};
        md   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        clear_q();
        r8_out = 1'b1;
        for (int i = 0; i < 5; i++) send8(v[i], md[i]);
        drain();
        checks++;
        if (got8.size() != 5) begin
            failures++; $display("FAIL maxsat_count got=%0d exp=5", got8.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (got8[i].res !== want[i] || got8[i].mode !== md[i]) begin
                    failures++; $display("FAIL maxsat_%0d got=%h/%b exp=%h/%b", i, got8[i].res, got8[i].mode, want[i], md[i]);
                end
            end
        end
    endtask

    task automatic test_n5();
        logic [5*W-1:0] a, b;
        for (int i = 0; i < 5; i++) begin
            a[i*W +: W] = 16'((i + 1) << 8);
            b[i*W +: W] = 16'h8100;
        end
        clear_q();
        r5_out = 1'b1;
        send5(a, 1'b0);
        send5(b, 1'b1);
        drain();
        checks++;
        if (got5.size() != 2) begin
            failures++; $display("FAIL n5_count got=%0d exp=2", got5.size());
        end else begin
            checks++; if (got5[0].res !== 16'h0F00) begin failures++; $display("FAIL n5_sum got=%h exp=0F00", got5[0].res); end
            checks++; if (got5[1].res !== 16'h8100) begin failures++; $display("FAIL n5_max got=%h exp=8100", got5[1].res); end
            checks++; if (got5[0].prop[5*W-1:0] !== a) begin failures++; $display("FAIL n5_prop got=%h exp=%h", got5[0].prop[5*W-1:0], a); end
            checks++; if (got5[0].cyc - exp5[0].cyc != 4) begin
                failures++; $display("FAIL n5_latency got=%0d exp=4", got5[0].cyc - exp5[0].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8*W-1:0] vec [6];
        logic [W-1:0]   held;
        logic           acc;
        int             idx;
        for (int n = 0; n < 6; n++)
            for (int i = 0; i < 8; i++) vec[n][i*W +: W] = rand_elem();
        clear_q();
        idx = 0;
        held = '0;
        for (int t = 0; t < 40; t++) begin
            r8_out = !(t >= 5 && t < 8);
            if (idx < 6) begin
                v8_in = 1'b1; in8 = vec[idx]; m8_in = idx[0];
            end else begin
                v8_in = 1'b0;
            end
            #1;
            if (t >= 5 && t < 8) begin
                checks++; if (r8_in !== 1'b0) begin failures++; $display("FAIL b2b_ready_t%0d got=%b exp=0", t, r8_in); end
                if (t == 5) held = out8;
                else begin
                    checks++; if (out8 !== held || v8_out !== 1'b1) begin
                        failures++; $display("FAIL b2b_hold_t%0d got=%h/%b exp=%h/1", t, out8, v8_out, held);
                    end
                end
            end
            acc = v8_in && r8_in;
            tick();
            if (acc) idx++;
        end
        v8_in = 1'b0;
        drain();
        checks++;
        if (got8.size() != 6 || exp8.size() != 6) begin
            failures++; $display("FAIL b2b_count got=%0d exp=6 sent=%0d", got8.size(), exp8.size());
        end else begin
            for (int n = 0; n < 6; n++) begin
                checks++; if (got8[n].res !== exp8[n].res || got8[n].mode !== n[0] || got8[n].prop !== vec[n]) begin
                    failures++; $display("FAIL b2b_item%0d got=%h/%b exp=%h/%b", n, got8[n].res, got8[n].mode, exp8[n].res, n[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic acc8, acc5, stall8, stall5;
        logic [W-1:0] prev8, prev5;
        clear_q();
        v8_in = 1'b0; v5_in = 1'b0; acc8 = 1'b1; acc5 = 1'b1;
        stall8 = 1'b0; stall5 = 1'b0; prev8 = '0; prev5 = '0;
        for (int t = 0; t < 300; t++) begin
            if (!v8_in || acc8) begin
                v8_in = ($urandom_range(0, 3) != 0); m8_in = 1'($urandom);
                for (int i = 0; i < 8; i++) in8[i*W +: W] = rand_elem();
            end
            if (!v5_in || acc5) begin
                v5_in = ($urandom_range(0, 3) != 0); m5_in = 1'($urandom);
                for (int i = 0; i < 5; i++) in5[i*W +: W] = rand_elem();
            end
            r8_out = ($urandom_range(0, 2) != 0);
            r5_out = ($urandom_range(0, 2) != 0);
            if (stall8) begin
                checks++; if (out8 !== prev8 || v8_out !== 1'b1) begin failures++; $display("FAIL rand_hold8 got=%h exp=%h", out8, prev8); end
            end
            if (stall5) begin
                checks++; if (out5 !== prev5 || v5_out !== 1'b1) begin failures++; $display("FAIL rand_hold5 got=%h exp=%h", out5, prev5); end
            end
            #1;
            acc8 = v8_in && r8_in; acc5 = v5_in && r5_in;
            stall8 = v8_out && !r8_out; stall5 = v5_out && !r5_out;
            prev8 = out8; prev5 = out5;
            tick();
        end
        drain();
        checks++;
        if (got8.size() != exp8.size() || got5.size() != exp5.size()) begin
            failures++; $display("FAIL rand_count got=%0d/%0d exp=%0d/%0d", got8.size(), got5.size(), exp8.size(), exp5.size());
        end
        for (int n = 0; n < exp8.size() && n < got8.size(); n++) begin
            checks++; if (got8[n] != exp8[n] && (got8[n].res !== exp8[n].res || got8[n].mode !== exp8[n].mode || got8[n].prop !== exp8[n].prop)) begin
                failures++; $display("FAIL rand8_item%0d got=%h/%b exp=%h/%b", n, got8[n].res, got8[n].mode, exp8[n].res, exp8[n].mode);
            end
        end
        for (int n = 0; n < exp5.size() && n < got5.size(); n++) begin
            checks++; if (got5[n].res !== exp5[n].res || got5[n].mode !== exp5[n].mode || got5[n].prop !== exp5[n].prop) begin
                failures++; $display("FAIL rand5_item%0d got=%h/%b exp=%h/%b", n, got5[n].res, got5[n].mode, exp5[n].res, exp5[n].mode);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [8*W-1:0] v;
        clear_q();
        r8_out = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) v[i*W +: W] = rand_elem();
            send8(v, 1'(n));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (v8_out !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", v8_out); end
        exp8.delete();
        for (int k = 0; k < 6; k++) tick();
        checks++; if (got8.size() != 0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", got8.size()); end
        for (int i = 0; i < 8; i++) v[i*W +: W] = 16'h0100;
        send8(v, 1'b0);
        drain();
        checks++;
        if (got8.size() != 1) begin
            failures++; $display("FAIL midrst_count got=%0d exp=1", got8.size());
        end else begin
            checks++; if (got8[0].res !== 16'h0800) begin failures++; $display("FAIL midrst_value got=%h exp=0800", got8[0].res); end
            checks++; if (got8[0].cyc - exp8[0].cyc != 4) begin
                failures++; $display("FAIL midrst_latency got=%0d exp=4", got8[0].cyc - exp8[0].cyc);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        v8_in = 1'b0; m8_in = 1'b0; in8 = '0; r8_out = 1'b1;
        v5_in = 1'b0; m5_in = 1'b0; in5 = '0; r5_out = 1'b1;
        test_reset();
        test_sum_basic();
        test_max_and_sat();
        test_n5();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
